raster_sequencer: RTL and testbench

RASTER_SEQUENCER -- requirements
Module: raster_sequencer

---
 rtl/raster_pkg.sv | 31 +++
 rtl/raster_pixel_fifo.sv | 55 +++++
 rtl/raster_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_raster_sequencer.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared types and widths for the raster sequencer and its pixel FIFO.
package raster_pkg;

   localparam int COORD_W = 16;
   localparam int DEPTH_W = 2;
   localparam int COLOR_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_BOUND,
      ST_EDGES,
      ST_SETUP,
      ST_RASTER,
      ST_DRAIN
   } state_t;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [DEPTH_W-1:0] depth;
   } vertex_t;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [DEPTH_W-1:0] depth;
      logic [COLOR_W-1:0] color;
   } pixel_t;

endpackage

// File: rtl/raster_pixel_fifo.sv
// Pixel FIFO between the rasterizer and the framebuffer writer.
// A push while full is accepted only together with a pop; pops on empty are ignored.
module raster_pixel_fifo
   import raster_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 push_i,
   input  pixel_t               push_data_i,
   input  logic                 pop_i,
   output pixel_t               pop_data_o,
   output logic                 full_o,
   output logic                 empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   pixel_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic               push_en;
   logic               pop_en;

   assign push_en = push_i && (!full_o || pop_i);
   assign pop_en  = pop_i && !empty_o;

   // storage, wrap-around pointers and occupancy
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push_en && !pop_en)      count_q <= count_q + 1'b1;
         else if (!push_en && pop_en) count_q <= count_q - 1'b1;
      end
   end

   assign pop_data_o = mem_q[rd_ptr_q];
   assign full_o     = (count_q == CNT_W'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;

endmodule

// File: rtl/raster_sequencer.sv
// Triangle raster sequencer: latches a triangle, steps the edge rasterizer
// through its setup stages, buffers emitted pixels and streams them out.
// Optional RASTER watchdog enabled by defining RASTER_SEQ_TIMEOUT_EN.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | ready for a triangle
// START     | start_new_triangle pulse
// BOUND     | get_boundary_coords pulse
// EDGES     | form_edges pulse
// SETUP     | pixel_loop_setup pulse
// RASTER    | rasterizer running, pixels pushed, stalls near FIFO full
// DRAIN     | waiting for the pixel FIFO to empty
module raster_sequencer
   import raster_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_tri_valid,
   output logic               out_tri_ready,
   input  logic [COORD_W-1:0] in_v0_screen_x,
   input  logic [COORD_W-1:0] in_v0_screen_y,
   input  logic [COORD_W-1:0] in_v1_screen_x,
   input  logic [COORD_W-1:0] in_v1_screen_y,
   input  logic [COORD_W-1:0] in_v2_screen_x,
   input  logic [COORD_W-1:0] in_v2_screen_y,
   input  logic [DEPTH_W-1:0] in_v0_depth,
   input  logic [DEPTH_W-1:0] in_v1_depth,
   input  logic [DEPTH_W-1:0] in_v2_depth,
   input  logic [COLOR_W-1:0] in_color,
   output logic [COORD_W-1:0] out_v0_screen_x,
   output logic [COORD_W-1:0] out_v0_screen_y,
   output logic [COORD_W-1:0] out_v1_screen_x,
   output logic [COORD_W-1:0] out_v1_screen_y,
   output logic [COORD_W-1:0] out_v2_screen_x,
   output logic [COORD_W-1:0] out_v2_screen_y,
   output logic [DEPTH_W-1:0] out_v0_depth,
   output logic [DEPTH_W-1:0] out_v1_depth,
   output logic [DEPTH_W-1:0] out_v2_depth,
   output logic [COLOR_W-1:0] out_color,
   output logic               out_sig_start_new_triangle,
   output logic               out_sig_get_boundary_coords,
   output logic               out_sig_form_edges,
   output logic               out_sig_pixel_loop_setup,
   output logic               out_sig_rasterize_pixels,
   input  logic               in_sig_rasterize_write_pixel,
   input  logic               in_sig_rasterize_done,
   input  logic [COORD_W-1:0] in_pixel_x,
   input  logic [COORD_W-1:0] in_pixel_y,
   input  logic [DEPTH_W-1:0] in_pixel_depth,
   input  logic [COLOR_W-1:0] in_pixel_color,
   output logic               out_pix_valid,
   input  logic               in_pix_ready,
   output logic [COORD_W-1:0] out_pix_x,
   output logic [COORD_W-1:0] out_pix_y,
   output logic [DEPTH_W-1:0] out_pix_depth,
   output logic [COLOR_W-1:0] out_pix_color,
   output logic               out_busy,
   output logic               out_overflow,
   output logic               out_timeout
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least 4");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   state_t             state_q;
   vertex_t            v0_q, v1_q, v2_q;
   logic [COLOR_W-1:0] color_q;
   logic               tri_ready_q, busy_q, overflow_q;
   logic               start_q, bound_q, edges_q, setup_q, rast_q;

   logic               push, pop, push_ok, ovf_evt, stall_d;
   logic               fifo_full, fifo_empty;
   logic [CNT_W-1:0]   fifo_count, cnt_d;
   pixel_t             push_pix, head_pix;

   assign push     = (state_q == ST_RASTER) && in_sig_rasterize_write_pixel;
   assign pop      = in_pix_ready && !fifo_empty;
   assign push_ok  = push && (!fifo_full || pop);
   assign ovf_evt  = push && fifo_full && !pop;
   assign push_pix = '{x: in_pixel_x, y: in_pixel_y, depth: in_pixel_depth, color: in_pixel_color};

   // post-edge occupancy, so the stall output tracks the count without lag
   always_comb begin
      cnt_d = fifo_count;
      if (push_ok && !pop)      cnt_d = fifo_count + 1'b1;
      else if (!push_ok && pop) cnt_d = fifo_count - 1'b1;
   end

   assign stall_d = (cnt_d >= CNT_W'(FIFO_DEPTH - 2));

   raster_pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock       (clock),
      .reset_n     (reset_n),
      .push_i      (push_ok),
      .push_data_i (push_pix),
      .pop_i       (pop),
      .pop_data_o  (head_pix),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

`ifdef RASTER_SEQ_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TMR_W-1:0] tmr_q;
   logic             timeout_q;
   assign out_timeout = timeout_q;
`else
   assign out_timeout = 1'b0;
`endif

   // sequencing FSM with registered stage controls and triangle latches
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         v0_q        <= '0;
         v1_q        <= '0;
         v2_q        <= '0;
         color_q     <= '0;
         tri_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         overflow_q  <= 1'b0;
         start_q     <= 1'b0;
         bound_q     <= 1'b0;
         edges_q     <= 1'b0;
         setup_q     <= 1'b0;
         rast_q      <= 1'b0;
`ifdef RASTER_SEQ_TIMEOUT_EN
         tmr_q       <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         start_q <= 1'b0;
         bound_q <= 1'b0;
         edges_q <= 1'b0;
         setup_q <= 1'b0;
         if (ovf_evt) overflow_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               tri_ready_q <= 1'b1;
               if (in_tri_valid && tri_ready_q) begin
                  v0_q        <= '{x: in_v0_screen_x, y: in_v0_screen_y, depth: in_v0_depth};
                  v1_q        <= '{x: in_v1_screen_x, y: in_v1_screen_y, depth: in_v1_depth};
                  v2_q        <= '{x: in_v2_screen_x, y: in_v2_screen_y, depth: in_v2_depth};
                  color_q     <= in_color;
                  tri_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  start_q     <= 1'b1;
                  state_q     <= ST_START;
               end
            end
            ST_START: begin
               bound_q <= 1'b1;
               state_q <= ST_BOUND;
            end
            ST_BOUND: begin
               edges_q <= 1'b1;
               state_q <= ST_EDGES;
            end
            ST_EDGES: begin
               setup_q <= 1'b1;
               state_q <= ST_SETUP;
            end
            ST_SETUP: begin
               rast_q  <= !stall_d;
               state_q <= ST_RASTER;
`ifdef RASTER_SEQ_TIMEOUT_EN
               tmr_q   <= '0;
`endif
            end
            ST_RASTER: begin
               if (in_sig_rasterize_done) begin
                  rast_q  <= 1'b0;
                  state_q <= ST_DRAIN;
               end
`ifdef RASTER_SEQ_TIMEOUT_EN
               else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                  timeout_q <= 1'b1;
                  rast_q    <= 1'b0;
                  state_q   <= ST_DRAIN;
               end
`endif
               else begin
                  rast_q <= !stall_d;
`ifdef RASTER_SEQ_TIMEOUT_EN
                  tmr_q  <= tmr_q + 1'b1;
`endif
               end
            end
            ST_DRAIN: begin
               if (fifo_empty) begin
                  busy_q      <= 1'b0;
                  tri_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               busy_q      <= 1'b0;
               rast_q      <= 1'b0;
               tri_ready_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign out_tri_ready               = tri_ready_q;
   assign out_busy                    = busy_q;
   assign out_overflow                = overflow_q;
   assign out_sig_start_new_triangle  = start_q;
   assign out_sig_get_boundary_coords = bound_q;
   assign out_sig_form_edges          = edges_q;
   assign out_sig_pixel_loop_setup    = setup_q;
   assign out_sig_rasterize_pixels    = rast_q;

   assign out_v0_screen_x = v0_q.x;
   assign out_v0_screen_y = v0_q.y;
   assign out_v0_depth    = v0_q.depth;
   assign out_v1_screen_x = v1_q.x;
   assign out_v1_screen_y = v1_q.y;
   assign out_v1_depth    = v1_q.depth;
   assign out_v2_screen_x = v2_q.x;
   assign out_v2_screen_y = v2_q.y;
   assign out_v2_depth    = v2_q.depth;
   assign out_color       = color_q;

   assign out_pix_valid = !fifo_empty;
   assign out_pix_x     = head_pix.x;
   assign out_pix_y     = head_pix.y;
   assign out_pix_depth = head_pix.depth;
   assign out_pix_color = head_pix.color;

endmodule

// File: tb/tb_raster_sequencer.sv
// Self-checking bench for raster_sequencer (FIFO_DEPTH=8, TIMEOUT_CYCLES=16).
module tb_raster_sequencer;
   import raster_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        in_tri_valid = 1'b0;
   logic        out_tri_ready;
   logic [15:0] in_v0_screen_x = '0, in_v0_screen_y = '0;
   logic [15:0] in_v1_screen_x = '0, in_v1_screen_y = '0;
   logic [15:0] in_v2_screen_x = '0, in_v2_screen_y = '0;
   logic [1:0]  in_v0_depth = '0, in_v1_depth = '0, in_v2_depth = '0;
   logic [15:0] in_color = '0;
   logic [15:0] out_v0_screen_x, out_v0_screen_y, out_v1_screen_x, out_v1_screen_y;
   logic [15:0] out_v2_screen_x, out_v2_screen_y, out_color;
   logic [1:0]  out_v0_depth, out_v1_depth, out_v2_depth;
   logic        out_sig_start_new_triangle, out_sig_get_boundary_coords, out_sig_form_edges;
   logic        out_sig_pixel_loop_setup, out_sig_rasterize_pixels;
   logic        in_sig_rasterize_write_pixel = 1'b0, in_sig_rasterize_done = 1'b0;
   logic [15:0] in_pixel_x = '0, in_pixel_y = '0, in_pixel_color = '0;
   logic [1:0]  in_pixel_depth = '0;
   logic        out_pix_valid, in_pix_ready = 1'b0;
   logic [15:0] out_pix_x, out_pix_y, out_pix_color;
   logic [1:0]  out_pix_depth;
   logic        out_busy, out_overflow, out_timeout;

   int     total = 0;
   int     bad = 0;
   int     n_popped = 0;
   pixel_t sb_q[$];
   pixel_t mon_got, mon_exp;

   always #5 clock = ~clock;

   raster_sequencer #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(16)) dut (
      .clock(clock), .reset_n(reset_n),
      .in_tri_valid(in_tri_valid), .out_tri_ready(out_tri_ready),
      .in_v0_screen_x(in_v0_screen_x), .in_v0_screen_y(in_v0_screen_y),
      .in_v1_screen_x(in_v1_screen_x), .in_v1_screen_y(in_v1_screen_y),
      .in_v2_screen_x(in_v2_screen_x), .in_v2_screen_y(in_v2_screen_y),
      .in_v0_depth(in_v0_depth), .in_v1_depth(in_v1_depth), .in_v2_depth(in_v2_depth),
      .in_color(in_color),
      .out_v0_screen_x(out_v0_screen_x), .out_v0_screen_y(out_v0_screen_y),
      .out_v1_screen_x(out_v1_screen_x), .out_v1_screen_y(out_v1_screen_y),
      .out_v2_screen_x(out_v2_screen_x), .out_v2_screen_y(out_v2_screen_y),
      .out_v0_depth(out_v0_depth), .out_v1_depth(out_v1_depth), .out_v2_depth(out_v2_depth),
      .out_color(out_color),
      .out_sig_start_new_triangle(out_sig_start_new_triangle),
      .out_sig_get_boundary_coords(out_sig_get_boundary_coords),
      .out_sig_form_edges(out_sig_form_edges),
      .out_sig_pixel_loop_setup(out_sig_pixel_loop_setup),
      .out_sig_rasterize_pixels(out_sig_rasterize_pixels),
      .in_sig_rasterize_write_pixel(in_sig_rasterize_write_pixel),
      .in_sig_rasterize_done(in_sig_rasterize_done),
      .in_pixel_x(in_pixel_x), .in_pixel_y(in_pixel_y),
      .in_pixel_depth(in_pixel_depth), .in_pixel_color(in_pixel_color),
      .out_pix_valid(out_pix_valid), .in_pix_ready(in_pix_ready),
      .out_pix_x(out_pix_x), .out_pix_y(out_pix_y),
      .out_pix_depth(out_pix_depth), .out_pix_color(out_pix_color),
      .out_busy(out_busy), .out_overflow(out_overflow), .out_timeout(out_timeout)
   );

   // scoreboard: every pop must match the oldest expected pixel
   always @(negedge clock) begin
      if (reset_n && out_pix_valid && in_pix_ready) begin
         total++;
         n_popped++;
         mon_got.x     = out_pix_x;
         mon_got.y     = out_pix_y;
         mon_got.depth = out_pix_depth;
         mon_got.color = out_pix_color;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL pix_unexpected: got %h, required no pixel", mon_got);
         end else begin
            mon_exp = sb_q.pop_front();
            if (mon_got !== mon_exp) begin
               bad++;
               $display("FAIL pix_order: got %h required %h", mon_got, mon_exp);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // returns one cycle after the accepting edge
   task automatic send_tri(input logic [15:0] x0, y0, x1, y1, x2, y2, col);
      int n = 0;
      in_v0_screen_x = x0; in_v0_screen_y = y0; in_v0_depth = 2'd1;
      in_v1_screen_x = x1; in_v1_screen_y = y1; in_v1_depth = 2'd2;
      in_v2_screen_x = x2; in_v2_screen_y = y2; in_v2_depth = 2'd3;
      in_color = col;
      in_tri_valid = 1'b1;
      while (out_tri_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      total++;
      if (out_tri_ready !== 1'b1) begin
         bad++;
         $display("FAIL tri_accept_wait: ready=%b required 1", out_tri_ready);
      end
      tick();
      in_tri_valid = 1'b0;
   endtask

   task automatic emit(input int k, input bit expect_kept);
      pixel_t p;
      p.x = 16'(300 + k); p.y = 16'(40 + 2 * k); p.depth = 2'(k); p.color = 16'(16'hA000 + k);
      in_pixel_x = p.x; in_pixel_y = p.y; in_pixel_depth = p.depth; in_pixel_color = p.color;
      in_sig_rasterize_write_pixel = 1'b1;
      if (expect_kept) sb_q.push_back(p);
      tick();
      in_sig_rasterize_write_pixel = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (out_tri_ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      total++;
      if (out_tri_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s_idle_wait: ready=%b required 1", tag, out_tri_ready);
      end
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      #1;
      total++;
      if ({out_tri_ready, out_busy, out_pix_valid, out_overflow, out_timeout, out_sig_rasterize_pixels} !== 6'b0) begin
         bad++;
         $display("FAIL reset_flags: got %b required 000000",
                  {out_tri_ready, out_busy, out_pix_valid, out_overflow, out_timeout, out_sig_rasterize_pixels});
      end
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      total++;
      if (out_tri_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_ready_early: got %b required 0", out_tri_ready);
      end
      tick();
      total++;
      if (out_tri_ready !== 1'b1 || out_busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_ready_after: ready=%b busy=%b required 1 0", out_tri_ready, out_busy);
      end
   endtask

   task automatic test_stage_pulses();
      logic [4:0] exp_v;
      logic [4:0] got_v;
      send_tri(16'd100, 16'd25, 16'd103, 16'd29, 16'd97, 16'd29, 16'hFF00);
      total++;
      if ({out_v0_screen_x, out_v0_screen_y, out_v1_screen_x, out_v2_screen_y, out_v2_depth, out_color}
          !== {16'd100, 16'd25, 16'd103, 16'd29, 2'd3, 16'hFF00}) begin
         bad++;
         $display("FAIL tri_latch: v0=(%0d,%0d) v1x=%0d v2y=%0d d2=%0d col=%h required (100,25) 103 29 3 ff00",
                  out_v0_screen_x, out_v0_screen_y, out_v1_screen_x, out_v2_screen_y, out_v2_depth, out_color);
      end
      for (int c = 1; c <= 5; c++) begin
         exp_v = 5'b10000 >> (c - 1);
         got_v = {out_sig_start_new_triangle, out_sig_get_boundary_coords, out_sig_form_edges,
                  out_sig_pixel_loop_setup, out_sig_rasterize_pixels};
         total++;
         if (got_v !== exp_v || out_busy !== 1'b1) begin
            bad++;
            $display("FAIL stage_cycle%0d: stages=%b busy=%b required %b 1", c, got_v, out_busy, exp_v);
         end
         if (c < 5) tick();
      end
      in_sig_rasterize_done = 1'b1;
      tick();
      in_sig_rasterize_done = 1'b0;
      total++;
      if (out_sig_rasterize_pixels !== 1'b0 || out_busy !== 1'b1) begin
         bad++;
         $display("FAIL stage_drain: rast=%b busy=%b required 0 1", out_sig_rasterize_pixels, out_busy);
      end
      wait_idle("stage");
   endtask

   task automatic test_stream();
      int p0;
      p0 = n_popped;
      send_tri(16'd100, 16'd25, 16'd103, 16'd29, 16'd97, 16'd29, 16'hFF00);
      repeat (4) tick();
      in_pix_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (k == 4) in_sig_rasterize_done = 1'b1;
         emit(k, 1'b1);
         in_sig_rasterize_done = 1'b0;
      end
      total++;
      if (out_v1_screen_x !== 16'd103 || out_busy !== 1'b1) begin
         bad++;
         $display("FAIL stream_hold_latch: v1x=%0d busy=%b required 103 1", out_v1_screen_x, out_busy);
      end
      wait_idle("stream");
      total++;
      if (n_popped - p0 != 5 || sb_q.size() != 0) begin
         bad++;
         $display("FAIL stream_count: popped=%0d left=%0d required 5 0", n_popped - p0, sb_q.size());
      end
      total++;
      if (out_overflow !== 1'b0 || out_busy !== 1'b0) begin
         bad++;
         $display("FAIL stream_flags: ovf=%b busy=%b required 0 0", out_overflow, out_busy);
      end
      in_pix_ready = 1'b0;
   endtask

   task automatic test_ignore_outside_raster();
      in_sig_rasterize_write_pixel = 1'b1;
      in_sig_rasterize_done = 1'b1;
      repeat (2) tick();
      in_sig_rasterize_write_pixel = 1'b0;
      in_sig_rasterize_done = 1'b0;
      total++;
      if (out_pix_valid !== 1'b0 || out_busy !== 1'b0 || out_tri_ready !== 1'b1) begin
         bad++;
         $display("FAIL ignore_idle: valid=%b busy=%b ready=%b required 0 0 1", out_pix_valid, out_busy, out_tri_ready);
      end
      send_tri(16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'h1234);
      in_sig_rasterize_write_pixel = 1'b1;
      in_sig_rasterize_done = 1'b1;
      repeat (3) tick();
      in_sig_rasterize_write_pixel = 1'b0;
      in_sig_rasterize_done = 1'b0;
      tick();
      total++;
      if (out_sig_rasterize_pixels !== 1'b1 || out_pix_valid !== 1'b0) begin
         bad++;
         $display("FAIL ignore_stages: rast=%b valid=%b required 1 0", out_sig_rasterize_pixels, out_pix_valid);
      end
      in_sig_rasterize_done = 1'b1;
      tick();
      in_sig_rasterize_done = 1'b0;
      wait_idle("ignore");
   endtask

   task automatic test_backpressure();
      int p0;
      p0 = n_popped;
      send_tri(16'd50, 16'd60, 16'd70, 16'd80, 16'd90, 16'd99, 16'h0F0F);
      repeat (4) tick();
      in_pix_ready = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         emit(k, 1'b1);
         total++;
         if (out_sig_rasterize_pixels !== (k < 6)) begin
            bad++;
            $display("FAIL stall_count%0d: rast=%b required %b", k, out_sig_rasterize_pixels, (k < 6));
         end
      end
      emit(7, 1'b1);
      emit(8, 1'b1);
      total++;
      if (out_pix_valid !== 1'b1 || out_pix_x !== sb_q[0].x || out_overflow !== 1'b0 || out_sig_rasterize_pixels !== 1'b0) begin
         bad++;
         $display("FAIL full_hold: valid=%b x=%0d ovf=%b rast=%b required 1 %0d 0 0",
                  out_pix_valid, out_pix_x, out_overflow, out_sig_rasterize_pixels, sb_q[0].x);
      end
      in_pix_ready = 1'b1;
      emit(9, 1'b1);
      in_pix_ready = 1'b0;
      total++;
      if (out_overflow !== 1'b0 || out_sig_rasterize_pixels !== 1'b0) begin
         bad++;
         $display("FAIL full_push_pop: ovf=%b rast=%b required 0 0", out_overflow, out_sig_rasterize_pixels);
      end
      emit(10, 1'b0);
      total++;
      if (out_overflow !== 1'b1 || out_pix_x !== sb_q[0].x) begin
         bad++;
         $display("FAIL overflow_set: ovf=%b x=%0d required 1 %0d", out_overflow, out_pix_x, sb_q[0].x);
      end
      in_pix_ready = 1'b1;
      repeat (2) tick();
      total++;
      if (out_sig_rasterize_pixels !== 1'b0) begin
         bad++;
         $display("FAIL stall_at6: rast=%b required 0", out_sig_rasterize_pixels);
      end
      tick();
      total++;
      if (out_sig_rasterize_pixels !== 1'b1) begin
         bad++;
         $display("FAIL stall_release: rast=%b required 1", out_sig_rasterize_pixels);
      end
      in_sig_rasterize_done = 1'b1;
      tick();
      in_sig_rasterize_done = 1'b0;
      wait_idle("backpressure");
      total++;
      if (n_popped - p0 != 9 || sb_q.size() != 0 || out_overflow !== 1'b1) begin
         bad++;
         $display("FAIL backpressure_drain: popped=%0d left=%0d ovf=%b required 9 0 1",
                  n_popped - p0, sb_q.size(), out_overflow);
      end
      in_pix_ready = 1'b0;
   endtask

   task automatic test_timeout();
      send_tri(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'h7777);
      repeat (4) tick();
`ifdef RASTER_SEQ_TIMEOUT_EN
      repeat (15) tick();
      total++;
      if (out_timeout !== 1'b0 || out_sig_rasterize_pixels !== 1'b1) begin
         bad++;
         $display("FAIL timeout_early: to=%b rast=%b required 0 1", out_timeout, out_sig_rasterize_pixels);
      end
      tick();
      total++;
      if (out_timeout !== 1'b1 || out_sig_rasterize_pixels !== 1'b0) begin
         bad++;
         $display("FAIL timeout_fire: to=%b rast=%b required 1 0", out_timeout, out_sig_rasterize_pixels);
      end
      wait_idle("timeout");
      total++;
      if (out_timeout !== 1'b1) begin
         bad++;
         $display("FAIL timeout_sticky: to=%b required 1", out_timeout);
      end
`else
      repeat (40) tick();
      total++;
      if (out_timeout !== 1'b0 || out_sig_rasterize_pixels !== 1'b1) begin
         bad++;
         $display("FAIL no_timeout: to=%b rast=%b required 0 1", out_timeout, out_sig_rasterize_pixels);
      end
      in_sig_rasterize_done = 1'b1;
      tick();
      in_sig_rasterize_done = 1'b0;
      wait_idle("no_timeout");
`endif
   endtask

   task automatic test_reset_in_raster();
      send_tri(16'd500, 16'd501, 16'd502, 16'd503, 16'd504, 16'd505, 16'hBEEF);
      repeat (4) tick();
      in_pix_ready = 1'b0;
      for (int k = 20; k < 23; k++) emit(k, 1'b1);
      total++;
      if (out_pix_valid !== 1'b1 || out_busy !== 1'b1) begin
         bad++;
         $display("FAIL pre_reset: valid=%b busy=%b required 1 1", out_pix_valid, out_busy);
      end
      #2 reset_n = 1'b0;
      #1;
      sb_q.delete();
      total++;
      if ({out_tri_ready, out_busy, out_pix_valid, out_overflow, out_timeout, out_sig_rasterize_pixels} !== 6'b0) begin
         bad++;
         $display("FAIL midreset_flags: got %b required 000000",
                  {out_tri_ready, out_busy, out_pix_valid, out_overflow, out_timeout, out_sig_rasterize_pixels});
      end
      total++;
      if (out_v0_screen_x !== 16'd0 || out_color !== 16'd0 || out_v2_screen_y !== 16'd0) begin
         bad++;
         $display("FAIL midreset_latch: v0x=%0d col=%h v2y=%0d required 0 0 0", out_v0_screen_x, out_color, out_v2_screen_y);
      end
      @(negedge clock);
      reset_n = 1'b1;
      tick();
      total++;
      if (out_tri_ready !== 1'b1 || out_pix_valid !== 1'b0 || out_busy !== 1'b0) begin
         bad++;
         $display("FAIL midreset_release: ready=%b valid=%b busy=%b required 1 0 0", out_tri_ready, out_pix_valid, out_busy);
      end
   endtask

   initial begin
      test_reset();
      test_stage_pulses();
      test_stream();
      test_ignore_outside_raster();
      test_backpressure();
      test_timeout();
      test_reset_in_raster();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
